imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address of first loaded word.
REQ-003 Parameter TIMEOUT_CYC, 1024, max idle cycles between bytes once a load has started.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 byte_valid_i  input  1  source offers byte_data_i.
REQ-007 byte_data_i  input  8  load stream byte.
REQ-008 byte_ready_o  output  1  loader accepts byte; transfer when valid and ready both high at a rising edge.
REQ-009 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-010 imem_addr_o  output  32  word-aligned byte address of write.
REQ-011 imem_wdata_o  output  32  instruction word.
REQ-012 core_rst_no  output  1  active-low reset to the processor core; low until load completes.
REQ-013 done_o  output  1  load completed successfully (sticky).
REQ-014 err_o  output  1  load aborted (sticky).

Function
REQ-015 Stream format SHALL be: 16-bit word count N (low byte first), then 4*N bytes, each word little-endian (first byte = bits 7:0).
REQ-016 FSM states SHALL be HDR_LO, HDR_HI, LOAD, WRITE, DONE, ERR.
REQ-017 HDR_LO -> HDR_HI on accepted byte (count low byte captured); no timeout in HDR_LO.
REQ-018 HDR_HI -> LOAD on accepted byte if 1 <= N <= DEPTH_WORDS, else -> ERR.
REQ-019 LOAD SHALL accept bytes into a 2-bit byte index; on 4th byte -> WRITE.
REQ-020 WRITE SHALL last exactly one cycle with imem_we_o=1, imem_addr_o = BASE_ADDR + 4*word_idx, imem_wdata_o = assembled word; then -> LOAD, or -> DONE if word_idx = N-1.
REQ-021 byte_ready_o SHALL be 1 only in HDR_LO, HDR_HI, LOAD; 0 in WRITE, DONE, ERR.
REQ-022 Write latency: 4th byte accepted at edge k -> imem_we_o high for the cycle between edges k and k+1.
REQ-023 word_idx SHALL be 16 bits, increment after each WRITE, never wrap (bounded by N <= DEPTH_WORDS).
REQ-024 Idle counter SHALL clear on every accepted byte and in HDR_LO; in HDR_HI and LOAD, reaching TIMEOUT_CYC cycles without an accepted byte -> ERR.
REQ-025 DONE: done_o=1, core_rst_no=1 from the cycle after the final WRITE; further bytes ignored.
REQ-026 ERR: err_o=1, core_rst_no stays 0, imem_we_o=0; exit only by reset.
REQ-027 imem_we_o SHALL be 0 in every state except WRITE; imem_addr_o/imem_wdata_o hold last values otherwise.
REQ-028 byte_valid_i high while byte_ready_o low SHALL NOT consume the byte; source holds it.

Reset
REQ-029 rst_ni low SHALL immediately force: state HDR_LO, byte_ready_o=1 after release, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, core_rst_no=0, done_o=0, err_o=0, counters 0.
REQ-030 Reset mid-load SHALL abandon the partial word with no write; subsequent load restarts at BASE_ADDR.

Structure
REQ-031 Package loader_pkg SHALL hold the state enum, header width (16), and parameter defaults.
REQ-032 Sub-module word_assembler SHALL hold byte index and 32-bit shift register, reporting word_valid on the 4th byte.

Verification
REQ-033 Bytes 02 00, 13 00 10 00, 93 00 20 00 -> writes (0x0, 0x00100013), (0x4, 0x00200093); done_o=1 and core_rst_no=1 one cycle after 2nd write.
REQ-034 Header 00 00 -> err_o=1 after 2nd byte, no write, core_rst_no=0.
REQ-035 Header with N=257 (01 01), DEPTH_WORDS=256 -> err_o=1, no write.
REQ-036 N=1, 2 data bytes then 1024 idle cycles -> err_o=1, imem_we_o never asserted.
REQ-037 byte_valid_i held high continuously, N=3 -> byte_ready_o low exactly one cycle after every 4th byte, 3 writes at 0x0/0x4/0x8, no byte lost.
REQ-038 rst_ni pulsed low after 6 of 8 data bytes -> all outputs to reset values, no write; fresh N=1 load writes at BASE_ADDR.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
package loader_pkg;

  // Loader sequencing: two header bytes, then alternating byte collection
  // and single-cycle memory writes, ending in one of two terminal states.
  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    WRITE,
    DONE,
    ERR
  } load_state_e;

  // Width of the word-count header at the front of the stream.
  localparam int HDR_W = 16;

  // Default parameter values for imem_loader.
  localparam int          DEF_DEPTH_WORDS = 256;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
  localparam int          DEF_TIMEOUT_CYC = 1024;

  // Byte address of word number idx, counted from base.
  function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                            input logic [HDR_W-1:0] idx);
    return base + {{(30-HDR_W){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four little-endian bytes into a 32-bit word. The fourth byte is
// combined on the fly so the complete word is visible in the same cycle that
// the fourth byte is presented.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_reg;
  logic [23:0] shift_reg;   // the three earlier bytes of the word in progress

  // Byte index and shift register advance on every accepted byte; the index
  // wraps to 0 after the fourth byte, ready for the next word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_en_i) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= {byte_i, shift_reg[23:8]};
    end
  end

  // First byte ends up in bits 7:0, fourth byte in bits 31:24.
  always_comb begin
    word_valid_o = byte_en_i && (idx_reg == 2'd3);
    word_o       = {byte_i, shift_reg};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream (16-bit word count then the words,
// little-endian), writes each word into instruction memory, and releases
// the core from reset once every word has landed.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_no,
  output logic        done_o,
  output logic        err_o
);

  localparam int          IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [HDR_W:0]    DEPTH_L   = (HDR_W+1)'(DEPTH_WORDS);

  load_state_e       state_reg,    state_next;
  logic [7:0]        count_lo_reg, count_lo_next;
  logic [HDR_W-1:0]  count_reg,    count_next;
  logic [HDR_W-1:0]  word_idx_reg, word_idx_next;
  logic [IDLE_W-1:0] idle_reg,     idle_next;
  logic [31:0]       addr_reg,     addr_next;
  logic [31:0]       wdata_reg,    wdata_next;

  logic              accept;
  logic              asm_en;
  logic              asm_valid;
  logic [31:0]       asm_word;
  logic [HDR_W-1:0]  hdr_count;

  // Only the header and data-collection states take bytes; during the write
  // cycle the source is stalled so the word index can advance.
  always_comb begin
    byte_ready_o = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                   (state_reg == LOAD);
    accept       = byte_valid_i && byte_ready_o;
    asm_en       = accept && (state_reg == LOAD);
    hdr_count    = {byte_data_i, count_lo_reg};
  end

  word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_en_i    (asm_en),
    .byte_i       (byte_data_i),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= HDR_LO;
      count_lo_reg <= 8'd0;
      count_reg    <= '0;
      word_idx_reg <= '0;
      idle_reg     <= '0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      count_lo_reg <= count_lo_next;
      count_reg    <= count_next;
      word_idx_reg <= word_idx_next;
      idle_reg     <= idle_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  // Next-state logic: header parsing, word collection, write sequencing and
  // the inter-byte timeout once a load is under way.
  always_comb begin
    state_next    = state_reg;
    count_lo_next = count_lo_reg;
    count_next    = count_reg;
    word_idx_next = word_idx_reg;
    idle_next     = idle_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;

    case (state_reg)
      HDR_LO: begin
        // Waiting for a host to start talking: no timeout here.
        idle_next = '0;
        if (accept) begin
          count_lo_next = byte_data_i;
          state_next    = HDR_HI;
        end
      end

      HDR_HI: begin
        if (accept) begin
          idle_next  = '0;
          count_next = hdr_count;
          if ((hdr_count != '0) && ({1'b0, hdr_count} <= DEPTH_L)) begin
            state_next = LOAD;
          end else begin
            state_next = ERR;
          end
        end else if (idle_reg == IDLE_LAST) begin
          state_next = ERR;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end

      LOAD: begin
        if (accept) begin
          idle_next = '0;
          if (asm_valid) begin
            addr_next  = word_addr(BASE_ADDR, word_idx_reg);
            wdata_next = asm_word;
            state_next = WRITE;
          end
        end else if (idle_reg == IDLE_LAST) begin
          state_next = ERR;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end

      WRITE: begin
        idle_next     = '0;
        word_idx_next = word_idx_reg + 1'b1;
        if (word_idx_reg == count_reg - 1'b1) begin
          state_next = DONE;
        end else begin
          state_next = LOAD;
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = ERR;
      end
    endcase
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    imem_we_o    = (state_reg == WRITE);
    imem_addr_o  = addr_reg;
    imem_wdata_o = wdata_reg;
    done_o       = (state_reg == DONE);
    err_o        = (state_reg == ERR);
    core_rst_no  = (state_reg == DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader.
module tb_imem_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_rst_no;
  logic        done_o;
  logic        err_o;

  int  checks = 0;
  int  errors = 0;
  wr_t wlog[$];

  imem_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_no  (core_rst_no),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every memory write, sampled well after the rising edge.
  always @(posedge clk) begin
    #2;
    if (imem_we_o === 1'b1) begin
      wlog.push_back('{a: imem_addr_o, d: imem_wdata_o});
      $display("write addr=%08h data=%08h", imem_addr_o, imem_wdata_o);
    end
  end

  // Offer one byte from a falling edge; returns at the falling edge after
  // the transfer edge with byte_valid_i still high.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    stalls = 0;
    while (byte_ready_o !== 1'b1 && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (byte_ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: ready=%b required=1", byte_ready_o);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_seq(input logic [7:0] q[$], output int stall_total);
    int s;
    stall_total = 0;
    foreach (q[i]) begin
      send_byte(q[i], s);
      stall_total += s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", imem_we_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr_o); end
    checks++; if (imem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", imem_wdata_o); end
    checks++; if ({core_rst_no, done_o, err_o} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {core_rst_no, done_o, err_o}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", byte_ready_o); end
    // No timeout while waiting for the first header byte.
    repeat (1100) @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL hdr_lo_no_timeout: err=%b want 0", err_o); end
  endtask

  task automatic test_basic_load();
    logic [7:0] q[$];
    int st;
    do_reset();
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if (imem_we_o !== 1'b1) begin errors++; $display("FAIL basic_we0: got %b want 1", imem_we_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h want 00000000", imem_addr_o); end
    checks++; if (imem_wdata_o !== 32'h0010_0013) begin errors++; $display("FAIL basic_data0: got %h want 00100013", imem_wdata_o); end
    checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_write: got %b want 0", byte_ready_o); end
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL basic_core_rst_mid: got %b want 0", core_rst_no); end
    @(negedge clk);
    checks++; if ({imem_we_o, byte_ready_o} !== 2'b01) begin errors++; $display("FAIL basic_after_write: we,ready=%b want 01", {imem_we_o, byte_ready_o}); end
    q = '{8'h93, 8'h00, 8'h20, 8'h00};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if ({imem_we_o, done_o} !== 2'b10) begin errors++; $display("FAIL basic_we1: we,done=%b want 10", {imem_we_o, done_o}); end
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL basic_addr1: got %h want 00000004", imem_addr_o); end
    checks++; if (imem_wdata_o !== 32'h0020_0093) begin errors++; $display("FAIL basic_data1: got %h want 00200093", imem_wdata_o); end
    @(negedge clk);
    checks++; if ({done_o, core_rst_no, imem_we_o, err_o} !== 4'b1100) begin errors++; $display("FAIL basic_done: done,core,we,err=%b want 1100", {done_o, core_rst_no, imem_we_o, err_o}); end
    checks++; if (imem_wdata_o !== 32'h0020_0093) begin errors++; $display("FAIL basic_wdata_hold: got %h want 00200093", imem_wdata_o); end
    // Bytes offered after completion must be ignored.
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hFF;
    repeat (5) @(negedge clk);
    checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL done_ready: got %b want 0", byte_ready_o); end
    byte_valid_i = 1'b0;
    checks++; if (wlog.size() !== 2) begin errors++; $display("FAIL basic_wcount: got %0d want 2", wlog.size()); end
    else begin
      checks++; if (wlog[0].a !== 32'h0 || wlog[0].d !== 32'h0010_0013) begin errors++; $display("FAIL basic_log0: got %h/%h want 00000000/00100013", wlog[0].a, wlog[0].d); end
      checks++; if (wlog[1].a !== 32'h4 || wlog[1].d !== 32'h0020_0093) begin errors++; $display("FAIL basic_log1: got %h/%h want 00000004/00200093", wlog[1].a, wlog[1].d); end
    end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", done_o); end
  endtask

  task automatic test_header_errors();
    logic [7:0] q[$];
    int st;
    // N = 0
    do_reset();
    q = '{8'h00, 8'h00};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if ({err_o, core_rst_no, done_o, byte_ready_o} !== 4'b1000) begin errors++; $display("FAIL zero_count: err,core,done,ready=%b want 1000", {err_o, core_rst_no, done_o, byte_ready_o}); end
    repeat (3) @(negedge clk);
    checks++; if (err_o !== 1'b1 || wlog.size() !== 0) begin errors++; $display("FAIL zero_sticky: err=%b writes=%0d want 1/0", err_o, wlog.size()); end
    // N = 257, above capacity
    do_reset();
    q = '{8'h01, 8'h01};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (err_o !== 1'b1 || wlog.size() !== 0 || core_rst_no !== 1'b0) begin errors++; $display("FAIL over_count: err=%b writes=%0d core=%b want 1/0/0", err_o, wlog.size(), core_rst_no); end
    // N = 256, exactly at capacity, is accepted
    do_reset();
    q = '{8'h00, 8'h01};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if ({err_o, byte_ready_o} !== 2'b01) begin errors++; $display("FAIL max_count: err,ready=%b want 01", {err_o, byte_ready_o}); end
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    int st;
    do_reset();
    q = '{8'h01, 8'h00, 8'h13, 8'h00};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    repeat (1023) @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL timeout_early: err=%b want 0 after 1023 idle", err_o); end
    @(negedge clk);
    checks++; if ({err_o, core_rst_no, byte_ready_o} !== 3'b100) begin errors++; $display("FAIL timeout: err,core,ready=%b want 100", {err_o, core_rst_no, byte_ready_o}); end
    checks++; if (wlog.size() !== 0) begin errors++; $display("FAIL timeout_nowrite: writes=%0d want 0", wlog.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int st;
    do_reset();
    q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if (st !== 2) begin errors++; $display("FAIL b2b_stalls: got %0d want 2", st); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done_o); end
    checks++; if (wlog.size() !== 3) begin errors++; $display("FAIL b2b_wcount: got %0d want 3", wlog.size()); end
    else begin
      checks++; if (wlog[0].a !== 32'h0 || wlog[0].d !== 32'h0403_0201) begin errors++; $display("FAIL b2b_log0: got %h/%h want 00000000/04030201", wlog[0].a, wlog[0].d); end
      checks++; if (wlog[1].a !== 32'h4 || wlog[1].d !== 32'h0807_0605) begin errors++; $display("FAIL b2b_log1: got %h/%h want 00000004/08070605", wlog[1].a, wlog[1].d); end
      checks++; if (wlog[2].a !== 32'h8 || wlog[2].d !== 32'h0C0B_0A09) begin errors++; $display("FAIL b2b_log2: got %h/%h want 00000008/0c0b0a09", wlog[2].a, wlog[2].d); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] q[$];
    int st;
    do_reset();
    q = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if (wlog.size() !== 1 || imem_wdata_o !== 32'hDDCC_BBAA) begin errors++; $display("FAIL mid_first_word: writes=%0d data=%h want 1/ddccbbaa", wlog.size(), imem_wdata_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({imem_we_o, core_rst_no, done_o, err_o} !== 4'b0000) begin errors++; $display("FAIL mid_reset_status: we,core,done,err=%b want 0000", {imem_we_o, core_rst_no, done_o, err_o}); end
    checks++; if (imem_wdata_o !== 32'h0 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_reset_bus: addr=%h data=%h want 0/0", imem_addr_o, imem_wdata_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wlog.size() !== 1) begin errors++; $display("FAIL mid_no_partial_write: writes=%0d want 1", wlog.size()); end
    wlog.delete();
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_seq(q, st);
    byte_valid_i = 1'b0;
    checks++; if (imem_we_o !== 1'b1 || imem_addr_o !== 32'h0 || imem_wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL mid_reload: we=%b addr=%h data=%h want 1/00000000/12345678", imem_we_o, imem_addr_o, imem_wdata_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || wlog.size() !== 1) begin errors++; $display("FAIL mid_reload_done: done=%b writes=%0d want 1/1", done_o, wlog.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_header_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
